// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
package pipe_pkg;

  localparam int OCC_W = 2;

  // Encoding equals the number of held beats, so occ is the state itself.
  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic one-cycle pipeline stage register with valid/ready handshake,
// synchronous flush and an optional two-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter bit                 SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occ
);

  // Handshake: a beat moves when valid and ready are both high on a rising
  // edge; a valid beat and its data are held stable until it is consumed.

  if (SKID) begin : g_skid
    stage_state_e      state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              consume;

    // in_ready depends on state flops only, so out_ready never reaches it.
    assign accept  = in_valid & (state != ST_TWO);
    assign consume = (state != ST_EMPTY) & out_ready;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state  <= ST_EMPTY;
        main_q <= RESET_VAL;
        skid_q <= RESET_VAL;
      end else if (flush) begin
        state  <= ST_EMPTY;
        main_q <= RESET_VAL;
        skid_q <= RESET_VAL;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (accept) begin
              state  <= ST_ONE;
              main_q <= in_data;
            end
          end
          ST_ONE: begin
            if (accept && consume) begin
              main_q <= in_data;
            end else if (accept) begin
              state  <= ST_TWO;
              skid_q <= in_data;
            end else if (consume) begin
              state <= ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (consume) begin
              state  <= ST_ONE;
              main_q <= skid_q;
            end
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_TWO);
    assign out_data  = main_q;
    assign occ       = state;
  end else begin : g_single
    logic              valid_q;
    logic [DATA_W-1:0] main_q;
    logic              accept;
    logic              consume;

    assign in_ready = !valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign consume  = valid_q & out_ready;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else if (flush) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else if (accept) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign occ       = {1'b0, valid_q};
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance.
module tb_pipe_stage_reg;

  localparam int          W    = 32;
  localparam logic [W-1:0] RV  = 32'h0000_3000;

  logic clk;
  logic rst;

  // SKID=1 instance signals
  logic         s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [W-1:0] s1_in_data, s1_out_data;
  logic [1:0]   s1_occ;

  // SKID=0 instance signals
  logic         s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [W-1:0] s0_in_data, s0_out_data;
  logic [1:0]   s0_occ;

  int checks;
  int errors;

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(RV), .SKID(1'b1)) dut_skid (
    .clk(clk), .rst(rst), .flush(s1_flush),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
    .occ(s1_occ)
  );

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(RV), .SKID(1'b0)) dut_single (
    .clk(clk), .rst(rst), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .occ(s0_occ)
  );

  // Clock: rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the SKID=1 inputs at a falling edge.
  task automatic drive_s1(input logic v, input logic [W-1:0] d, input logic r,
                          input logic f);
    @(negedge clk);
    s1_in_valid  = v;
    s1_in_data   = d;
    s1_out_ready = r;
    s1_flush     = f;
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s1_flush = 0; s1_in_valid = 0; s1_in_data = '0; s1_out_ready = 0;
    s0_flush = 0; s0_in_valid = 0; s0_in_data = '0; s0_out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (s1_out_data !== RV || s1_out_valid !== 1'b0 || s1_in_ready !== 1'b1 ||
        s1_occ !== 2'd0) begin
      errors++;
      $display("FAIL reset_skid: data=%h valid=%b ready=%b occ=%0d, required data=%h valid=0 ready=1 occ=0",
               s1_out_data, s1_out_valid, s1_in_ready, s1_occ, RV);
    end
    checks++;
    if (s0_out_data !== RV || s0_out_valid !== 1'b0 || s0_in_ready !== 1'b1 ||
        s0_occ !== 2'd0) begin
      errors++;
      $display("FAIL reset_single: data=%h valid=%b ready=%b occ=%0d, required data=%h valid=0 ready=1 occ=0",
               s0_out_data, s0_out_valid, s0_in_ready, s0_occ, RV);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 16; i++) begin
      drive_s1(1'b1, W'(i), 1'b1, 1'b0);
      #1;
      checks++;
      if (s1_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d]: in_ready=%b, required 1", i, s1_in_ready);
      end
      step();
      checks++;
      if (s1_out_valid !== 1'b1 || s1_out_data !== W'(i) || s1_occ !== 2'd1) begin
        errors++;
        $display("FAIL stream_beat[%0d]: valid=%b data=%h occ=%0d, required valid=1 data=%h occ=1",
                 i, s1_out_valid, s1_out_data, s1_occ, W'(i));
      end
    end
    drive_s1(1'b0, '0, 1'b1, 1'b0);
    step();
    checks++;
    if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: valid=%b occ=%0d, required valid=0 occ=0",
               s1_out_valid, s1_occ);
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] exp_q[$];
    exp_q = '{32'hA, 32'hB, 32'hC};
    drive_s1(1'b1, 32'hA, 1'b1, 1'b0);
    step();
    drive_s1(1'b1, 32'hB, 1'b0, 1'b0);
    step();
    // C is offered while full and must wait.
    drive_s1(1'b1, 32'hC, 1'b0, 1'b0);
    step();
    checks++;
    if (s1_occ !== 2'd2 || s1_in_ready !== 1'b0 || s1_out_data !== 32'hA ||
        s1_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: occ=%0d ready=%b data=%h valid=%b, required occ=2 ready=0 data=a valid=1",
               s1_occ, s1_in_ready, s1_out_data, s1_out_valid);
    end
    // Head A is consumed on the next edge.
    drive_s1(1'b1, 32'hC, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    step();
    checks++;
    if (s1_in_ready !== 1'b1 || s1_out_data !== exp_q[0] || s1_occ !== 2'd1) begin
      errors++;
      $display("FAIL bp_after_first: ready=%b data=%h occ=%0d, required ready=1 data=%h occ=1",
               s1_in_ready, s1_out_data, s1_occ, exp_q[0]);
    end
    drive_s1(1'b1, 32'hC, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    step();
    checks++;
    if (s1_out_valid !== 1'b1 || s1_out_data !== exp_q[0] || s1_occ !== 2'd1) begin
      errors++;
      $display("FAIL bp_third: valid=%b data=%h occ=%0d, required valid=1 data=%h occ=1",
               s1_out_valid, s1_out_data, s1_occ, exp_q[0]);
    end
    drive_s1(1'b0, '0, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    step();
    checks++;
    if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b occ=%0d left=%0d, required valid=0 occ=0 left=0",
               s1_out_valid, s1_occ, exp_q.size());
    end
  endtask

  task automatic test_flush_full();
    drive_s1(1'b1, 32'h1, 1'b0, 1'b0);
    step();
    drive_s1(1'b1, 32'h2, 1'b0, 1'b0);
    step();
    checks++;
    if (s1_occ !== 2'd2) begin
      errors++;
      $display("FAIL flush_fill: occ=%0d, required 2", s1_occ);
    end
    drive_s1(1'b1, 32'hDEAD, 1'b0, 1'b1);
    step();
    checks++;
    if (s1_occ !== 2'd0 || s1_out_valid !== 1'b0 || s1_out_data !== RV ||
        s1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: occ=%0d valid=%b data=%h ready=%b, required occ=0 valid=0 data=%h ready=1",
               s1_occ, s1_out_valid, s1_out_data, s1_in_ready, RV);
    end
    for (int i = 0; i < 3; i++) begin
      drive_s1(1'b0, '0, 1'b1, 1'b0);
      step();
      checks++;
      if (s1_out_valid !== 1'b0 || s1_out_data === 32'hDEAD) begin
        errors++;
        $display("FAIL flush_no_dead[%0d]: valid=%b data=%h, required valid=0 and no dead",
                 i, s1_out_valid, s1_out_data);
      end
    end
  endtask

  task automatic test_single_pass();
    @(negedge clk);
    s0_in_valid = 1'b1; s0_in_data = 32'h33; s0_out_ready = 1'b0; s0_flush = 1'b0;
    step();
    checks++;
    if (s0_out_valid !== 1'b1 || s0_out_data !== 32'h33 || s0_occ !== 2'd1) begin
      errors++;
      $display("FAIL single_load: valid=%b data=%h occ=%0d, required valid=1 data=33 occ=1",
               s0_out_valid, s0_out_data, s0_occ);
    end
    @(negedge clk);
    s0_in_valid = 1'b1; s0_in_data = 32'h55; s0_out_ready = 1'b0;
    #1;
    checks++;
    if (s0_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_low: in_ready=%b, required 0", s0_in_ready);
    end
    s0_out_ready = 1'b1;
    #1;
    checks++;
    if (s0_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_comb: in_ready=%b, required 1", s0_in_ready);
    end
    step();
    checks++;
    if (s0_out_valid !== 1'b1 || s0_out_data !== 32'h55 || s0_occ !== 2'd1) begin
      errors++;
      $display("FAIL single_swap: valid=%b data=%h occ=%0d, required valid=1 data=55 occ=1",
               s0_out_valid, s0_out_data, s0_occ);
    end
    @(negedge clk);
    s0_in_valid = 1'b0; s0_out_ready = 1'b1;
    step();
    checks++;
    if (s0_out_valid !== 1'b0 || s0_occ !== 2'd0) begin
      errors++;
      $display("FAIL single_drain: valid=%b occ=%0d, required valid=0 occ=0",
               s0_out_valid, s0_occ);
    end
    // Flush discards a held beat and the offered one.
    @(negedge clk);
    s0_in_valid = 1'b1; s0_in_data = 32'h66; s0_out_ready = 1'b0;
    step();
    @(negedge clk);
    s0_in_data = 32'h77; s0_flush = 1'b1;
    step();
    checks++;
    if (s0_out_valid !== 1'b0 || s0_out_data !== RV) begin
      errors++;
      $display("FAIL single_flush: valid=%b data=%h, required valid=0 data=%h",
               s0_out_valid, s0_out_data, RV);
    end
    @(negedge clk);
    s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    drive_s1(1'b1, 32'h11, 1'b0, 1'b0);
    step();
    drive_s1(1'b1, 32'h22, 1'b0, 1'b0);
    step();
    checks++;
    if (s1_occ !== 2'd2) begin
      errors++;
      $display("FAIL areset_fill: occ=%0d, required 2", s1_occ);
    end
    drive_s1(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0 || s1_out_data !== RV ||
        s1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_immediate: valid=%b occ=%0d data=%h ready=%b, required valid=0 occ=0 data=%h ready=1",
               s1_out_valid, s1_occ, s1_out_data, s1_in_ready, RV);
    end
    @(negedge clk);
    rst = 1'b1;
    s1_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s1_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL areset_stale[%0d]: valid=%b data=%h, required valid=0",
                 i, s1_out_valid, s1_out_data);
      end
    end
    drive_s1(1'b1, 32'h77, 1'b1, 1'b0);
    step();
    checks++;
    if (s1_out_valid !== 1'b1 || s1_out_data !== 32'h77) begin
      errors++;
      $display("FAIL areset_resume: valid=%b data=%h, required valid=1 data=77",
               s1_out_valid, s1_out_data);
    end
    drive_s1(1'b0, '0, 1'b1, 1'b0);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_full();
    test_single_pass();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a task never returns.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the generic replacement for the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Each instance carries one packed payload bus and inserts exactly one cycle of latency. Downstream back-pressure, upstream starvation and flushes from branch/exception resolution are handled inside the block.

## Interface
- DATA_W, 32: payload width in bits; legal range 1..512.
- RESET_VAL, 0 (DATA_W bits): value driven on out_data after reset or flush.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries; highest priority after rst.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a beat for downstream.
- out_ready  in  1  downstream consumes the head beat this cycle.
- out_data  out  DATA_W  head payload.
- occ  out  2  number of held beats (0..2; at most 1 when SKID=0).

## Operation
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Reset (rst low, asynchronous) sets:
  - out_valid = 0, out_data = RESET_VAL, occ = 0, in_ready = 1.
  - Skid entry = RESET_VAL.
- SKID=1 state machine (EMPTY, ONE, TWO):
  - State decode: out_valid = (state != EMPTY); in_ready = (state != TWO), decoded from flops only; occ = 0/1/2.
  - EMPTY: accept -> ONE, main <= in_data.
  - ONE, accept and consume -> ONE, main <= in_data.
  - ONE, accept only -> TWO, skid <= in_data.
  - ONE, consume only -> EMPTY, main holds its value.
  - ONE, neither -> ONE.
  - TWO (in_ready = 0): consume -> ONE, main <= skid. Otherwise hold.
- SKID=0:
  - Single register. in_ready = !out_valid | out_ready (combinational).
  - Accept loads main and sets out_valid. Consume without accept clears out_valid.
- Flush:
  - On the next edge: state -> EMPTY, out_valid = 0, main <= RESET_VAL, skid <= RESET_VAL.
  - A beat offered in the flush cycle is discarded even if in_ready is high. Upstream treats it as consumed.
  - A downstream consume in the flush cycle still counts as a consume. The flush only removes the remaining entries.
- Data stability: while out_valid & !out_ready, out_data and out_valid stay constant.
- No beat is duplicated, reordered or lost except by flush.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle sustained in both modes when out_ready stays high.
- SKID=1 has no combinational path from out_ready to in_ready. The full in_valid/out_ready bandwidth is kept across one cycle of back-pressure.
- SKID=0 has a combinational path out_ready -> in_ready. Use it only where the timing allows.
- Reset deassertion: the first accept is possible on the first rising edge after rst goes high.
- Reset asserted mid-operation: all held beats are dropped immediately and outputs go to their reset values asynchronously.
- Flush and rst both active: rst wins. Flush has no effect while rst is low.

## Structure
- Shared package pipe_pkg holds:
  - typedef enum for the stage state {ST_EMPTY, ST_ONE, ST_TWO};
  - localparam OCC_W = 2.
- Payload packing per stage (Jtarget, ALUres, busB, Rw, control fields, …) is done by the instantiating stage, not here.
- No sub-module. Both modes live in one module selected by a generate on SKID. The skid flop is only instantiated when SKID=1.

## Test plan
- Reset/idle (DATA_W=32, RESET_VAL=32'h00003000): hold rst low for 3 cycles, release. Required: out_data=32'h00003000, out_valid=0, in_ready=1, occ=0.
- Streaming (SKID=1): drive 0x1..0x10 on consecutive cycles with out_ready=1. Required: the same sequence appears one cycle later, one beat per cycle, occ never exceeds 1.
- Back-pressure (SKID=1): send 0xA, 0xB, 0xC with out_ready=0 from the second cycle.
  - Required: occ reaches 2 and in_ready drops; 0xA is held on out_data.
  - Then raise out_ready. Required: 0xA, 0xB, 0xC delivered in order with no loss; in_ready returns one cycle after the first consume.
- Flush while full (SKID=1): with occ=2, assert flush together with in_valid=1, in_data=0xDEAD. Required: next cycle occ=0, out_valid=0, out_data=RESET_VAL, and 0xDEAD is never emitted.
- SKID=0 pass-through: set out_ready=0 with one beat held. Required: in_ready=0 in the same cycle. Set out_ready=1 while in_valid=1 with data 0x55. Required: the held beat is consumed and 0x55 is loaded on the same edge.
- Async reset mid-stream: assert rst between clock edges while occ=2. Required: out_valid goes to 0 before the next edge; after release no stale beat appears.
